stream_source: RTL and testbench
================================

Name: stream_source

Overview:
- Valid/ready stream transmitter: the producing end of the team's valid/ready pipeline stages.
- Accepts one command (base, stride, count) and emits `count` data beats: base, base+stride, base+2*stride, ...
- Holds each beat stable under backpressure and flags the final beat with `out_last`.
- Used as the upstream driver of pipeline-register chains, as a DMA-style address generator and as a bench traffic source.

Parameters:
WIDTH, 32, data and stride width in bits
CNT_W, 16, width of beat-count field; max burst 2^CNT_W-1 beats

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_base  input  WIDTH  first data value
cmd_stride  input  WIDTH  increment between beats (unsigned, modulo 2^WIDTH)
cmd_count  input  CNT_W  number of beats to emit
out_data  output  WIDTH  stream data
out_valid  output  1  stream beat present
out_ready  input  1  downstream accepts beat
out_last  output  1  current beat is the final beat of the command
busy  output  1  command in progress (state SEND)
done  output  1  one-cycle pulse: command completed

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. Reset state takes effect at the first rising edge with rst=1.
- Reset values: state=IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, remaining=0. cmd_ready=1 from the first cycle after reset deasserts.
- States:
  - IDLE: cmd_ready=1, out_valid=0.
  - SEND: cmd_ready=0, busy=1, out_valid=1.
- Command handshake: a command is accepted on the edge where cmd_valid&&cmd_ready. base, stride and count are captured into registers at that edge; later changes on cmd_* have no effect.
- count==0: accepted and no beats emitted. State stays IDLE. done=1 in the following cycle only.
- count>=1:
  - Next cycle: state=SEND, out_valid=1, out_data=base, remaining=count.
  - Latency from accept to first out_valid is 1 cycle.
  - out_last = (remaining==1), driven from registered state.
- Beat transfer on every edge with out_valid&&out_ready:
  - If remaining>1: out_data <= out_data+stride, truncated to WIDTH, wraps modulo 2^WIDTH with no saturation or flag. remaining <= remaining-1.
  - If remaining==1: state <= IDLE, out_valid <= 0, out_last <= 0, done <= 1 for exactly one cycle.
- Backpressure: while out_valid&&!out_ready, out_data, out_valid and out_last hold their values. out_valid never drops without a handshake.
- out_ready held high: one beat per cycle. A count=N command occupies N+1 cycles from accept edge to done pulse.
- Back-to-back commands: next command is accepted in the cycle done=1 (state is IDLE). Its first beat appears 1 cycle later, giving one bubble cycle between commands.
- out_ready while out_valid=0: ignored.
- cmd_valid in SEND: ignored; cmd_ready=0, so the command is not consumed.
- Reset mid-burst:
  - All outputs return to reset values on the next edge.
  - No done pulse is produced.
  - The partially sent command is discarded, with no resume.
- Max count (2^CNT_W-1): must complete. Internal counter is CNT_W bits and never underflows.
- Outputs out_valid, out_data, out_last, busy and done are registered. cmd_ready is decoded from the state register only, with no combinational path from any input.

Test Plan:
- Basic burst: base=0x10, stride=4, count=4, out_ready=1 -> out_data 0x10,0x14,0x18,0x1C on 4 consecutive cycles. out_last only on 0x1C. done pulses 1 cycle after the 0x1C handshake. cmd_ready low throughout SEND.
- Backpressure: base=0x100, stride=1, count=3, out_ready toggling 1,0,0,1,0,1 -> beats 0x100,0x101,0x102 each held stable while out_ready=0. Exactly 3 handshakes, no duplicates or drops.
- Wrap and zero count: WIDTH=8, base=0xFE, stride=3, count=3 -> out_data 0xFE,0x01,0x04. Then count=0 -> no out_valid, single done pulse the cycle after accept.
- Back-to-back: second command (base=0xA0, stride=0x10, count=2) held valid during the first burst -> accepted in the done cycle. Beats 0xA0,0xB0 follow after one bubble. cmd_valid during SEND not consumed.
- Reset mid-burst: count=8, assert rst after 3rd beat with out_ready=0 -> next cycle out_valid=0, busy=0, done=0, cmd_ready=1 after rst deasserts. A fresh command (base=0, stride=1, count=2) then runs correctly.
- Random: random commands, stride and out_ready stalls for 10k cycles -> scoreboard matches expected sequence. Checker asserts out_valid/out_data/out_last stable under stall and out_last only on the final beat.

Source files
------------

// File: rtl/stream_source_if.sv
// Command and stream handshake bundle for stream_source.
// master is the generator side, slave is the consumer/commander side.
interface stream_source_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_base;
    logic [WIDTH-1:0] cmd_stride;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        input  cmd_valid, cmd_base, cmd_stride, cmd_count, out_ready,
        output cmd_ready, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_stride, cmd_count, out_ready,
        input  cmd_ready, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/stream_source.sv
// Valid/ready stream generator: one command (base, stride, count)
// becomes count beats base, base+stride, ... with last on the final beat.
module stream_source #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    stream_source_if.master bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic [WIDTH-1:0] stride_q, stride_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic             last_q, last_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_q   <= data_nxt;
            stride_q <= stride_nxt;
            rem_q    <= rem_nxt;
            last_q   <= last_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_nxt   = data_q;
        stride_nxt = stride_q;
        rem_nxt    = rem_q;
        last_nxt   = last_q;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    stride_nxt = bus.cmd_stride;
                    if (bus.cmd_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = SEND;
                        data_nxt  = bus.cmd_base;
                        rem_nxt   = bus.cmd_count;
                        last_nxt  = (bus.cmd_count == CNT_W'(1));
                    end
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (rem_q == CNT_W'(1)) begin
                        // final beat: leave data as-is, count to zero
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        data_nxt = data_q + stride_q;
                        rem_nxt  = rem_q - CNT_W'(1);
                        last_nxt = (rem_q == CNT_W'(2));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.out_valid = (state == SEND);
    assign bus.busy      = (state == SEND);
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_stream_source.sv
// Directed and random checks of stream_source against a beat scoreboard.
// Outputs are sampled on the falling edge; inputs change just after rising.
module tb_stream_source;
    localparam int W = 16;
    localparam int C = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_source_if #(.WIDTH(W), .CNT_W(C)) bus ();

    stream_source #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    beat_t        q[$];
    int           total = 0;
    int           bad = 0;
    int           hs_cnt = 0;
    int           last_cnt = 0;
    logic         acc = 1'b0;
    logic         stall_p = 1'b0;
    logic [W-1:0] data_p = '0;
    logic         last_p = 1'b0;
    bit           pat[6] = '{1, 0, 0, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        beat_t e;
        @(negedge clk);
        acc = bus.cmd_valid && bus.cmd_ready && !rst;
        if (stall_p) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data", 32'(bus.out_data), 32'(data_p));
            chk("stall_last", 32'(bus.out_last), 32'(last_p));
        end
        if (bus.out_valid) chk("rdy_in_send", 32'(bus.cmd_ready), 0);
        if (bus.done) chk("done_q_empty", q.size(), 0);
        if (bus.out_valid && bus.out_ready && !rst) begin
            hs_cnt++;
            if (bus.out_last) last_cnt++;
            chk("beat_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("beat_data", 32'(bus.out_data), 32'(e.d));
                chk("beat_last", 32'(bus.out_last), 32'(e.l));
            end
        end
        stall_p = bus.out_valid && !bus.out_ready && !rst;
        data_p  = bus.out_data;
        last_p  = bus.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [W-1:0] b, input logic [W-1:0] s,
                            input logic [C-1:0] n, output int waited);
        logic [W-1:0] d;
        bus.cmd_valid  = 1'b1;
        bus.cmd_base   = b;
        bus.cmd_stride = s;
        bus.cmd_count  = n;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (!acc && waited < 1000);
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = ~b;
        bus.cmd_stride = s + 16'd7;
        bus.cmd_count  = ~n;
        chk("cmd_accept", 32'(acc), 1);
        if (acc) begin
            d = b;
            for (int i = 0; i < int'(n); i++) begin
                q.push_back('{d: d, l: (i == int'(n) - 1)});
                d = d + s;
            end
        end
    endtask

    task automatic wait_done(input bit rnd, output int n);
        n = 1;
        while (!bus.done && n < 2000) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        chk("done_seen", 32'(bus.done), 1);
    endtask

    initial begin
        int w;
        int n;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_stride = '0;
        bus.cmd_count  = '0;
        bus.out_ready  = 1'b0;
        cycle();
        cycle();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        rst = 1'b0;
        cycle();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);

        bus.out_ready = 1'b1;
        hs_cnt = 0;
        last_cnt = 0;
        send_cmd(16'h10, 16'd4, 8'd4, w);
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("lat_data", 32'(bus.out_data), 32'h10);
        chk("lat_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("lat_busy", 32'(bus.busy), 1);
        wait_done(1'b0, n);
        chk("basic_cycles", n, 5);
        chk("basic_beats", hs_cnt, 4);
        chk("basic_lasts", last_cnt, 1);
        cycle();
        chk("basic_done_pulse", 32'(bus.done), 0);

        bus.out_ready = 1'b0;
        send_cmd(16'h100, 16'd1, 8'd3, w);
        hs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = pat[i];
            cycle();
        end
        chk("bp_beats", hs_cnt, 3);
        chk("bp_done", 32'(bus.done), 1);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_done_pulse", 32'(bus.done), 0);

        send_cmd(16'hFFFE, 16'd3, 8'd3, w);
        wait_done(1'b0, n);
        chk("wrap_cycles", n, 4);
        cycle();
        send_cmd(16'h55, 16'd9, 8'd0, w);
        chk("zero_done", 32'(bus.done), 1);
        chk("zero_valid", 32'(bus.out_valid), 0);
        chk("zero_busy", 32'(bus.busy), 0);
        cycle();
        chk("zero_done_pulse", 32'(bus.done), 0);
        chk("zero_valid2", 32'(bus.out_valid), 0);

        send_cmd(16'h50, 16'd1, 8'd3, w);
        send_cmd(16'hA0, 16'h10, 8'd2, w);
        chk("b2b_wait", w, 4);
        chk("b2b_valid", 32'(bus.out_valid), 1);
        chk("b2b_data", 32'(bus.out_data), 32'hA0);
        wait_done(1'b0, n);
        chk("b2b_cycles", n, 3);
        cycle();

        hs_cnt = 0;
        send_cmd(16'h20, 16'd2, 8'd8, w);
        repeat (3) cycle();
        chk("mid_beats", hs_cnt, 3);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_done", 32'(bus.done), 0);
        chk("mid_last", 32'(bus.out_last), 0);
        chk("mid_data", 32'(bus.out_data), 0);
        q.delete();
        rst = 1'b0;
        cycle();
        chk("mid_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mid_no_done", 32'(bus.done), 0);
        bus.out_ready = 1'b1;
        send_cmd(16'h0, 16'd1, 8'd2, w);
        wait_done(1'b0, n);
        chk("mid_fresh_cycles", n, 3);
        cycle();

        send_cmd(16'h0, 16'd1, 8'd255, w);
        wait_done(1'b0, n);
        chk("max_cycles", n, 256);
        cycle();

        for (int k = 0; k < 400; k++) begin
            logic [C-1:0] cnt;
            bus.out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) cycle();
            cnt = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
            send_cmd(16'($urandom), 16'($urandom), cnt, w);
            wait_done(1'b1, n);
            chk("rnd_q_empty", q.size(), 0);
        end
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
